// File: rtl/mem_arb_pkg.sv
// Shared types for the IFU/LSU memory port arbiter.
// Build option: MEM_ARB_LSU_PRIORITY_EN selects fixed LSU priority.
package mem_arb_pkg;

  typedef enum logic {
    ARB_IDLE,
    ARB_BUSY
  } arb_state_e;

  typedef enum logic {
    OWN_IFU,
    OWN_LSU
  } arb_owner_e;

  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b10;
  localparam logic [1:0] MEM_EXTA = 2'b11;

endpackage

// File: rtl/mem_arb_pick.sv
// Two-way request picker for the memory port arbiter.
// MEM_ARB_LSU_PRIORITY_EN: LSU always wins; otherwise round-robin.
module mem_arb_pick (
  input  logic cand_ifu,
  input  logic cand_lsu,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_lsu
);

  assign grant_valid = cand_ifu | cand_lsu;

`ifdef MEM_ARB_LSU_PRIORITY_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
  assign grant_lsu = cand_lsu;
`else
  // On a tie the side that did not win last time goes first.
  assign grant_lsu = cand_lsu & (~cand_ifu | ~last_grant);
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares the SoC memory/IO port between instruction fetch and load/store.
// Build option: MEM_ARB_LSU_PRIORITY_EN (see mem_arb_pick).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ifu_reqValid,
  input  logic [ADDR_W-1:0] ifu_addr,
  output logic              ifu_respValid,
  output logic [DATA_W-1:0] ifu_rdata,
  input  logic              lsu_reqValid,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic [DATA_W-1:0] lsu_wdata,
  input  logic [1:0]        lsu_size,
  input  logic              lsu_wen,
  input  logic [3:0]        lsu_wmask,
  output logic              lsu_respValid,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic              io_reqValid,
  input  logic              io_respValid,
  output logic [ADDR_W-1:0] io_addr,
  output logic [DATA_W-1:0] io_wdata,
  input  logic [DATA_W-1:0] io_rdata,
  output logic [1:0]        io_size,
  output logic              io_wen,
  output logic [3:0]        io_wmask
);

  arb_state_e state;
  arb_owner_e owner;
  logic       pend_ifu;
  logic       pend_lsu;
  logic       last_grant;

  logic cand_ifu;
  logic cand_lsu;
  logic grant_valid;
  logic grant_lsu;
  logic owner_lsu;
  logic own_req;
  logic sel_lsu;
  logic req_fire;
  logic resp_ifu;
  logic resp_lsu;

  assign cand_ifu  = ifu_reqValid | pend_ifu;
  assign cand_lsu  = lsu_reqValid | pend_lsu;
  assign owner_lsu = (owner == OWN_LSU);
  assign own_req   = owner_lsu ? lsu_reqValid : ifu_reqValid;

  mem_arb_pick u_pick (
    .cand_ifu    (cand_ifu),
    .cand_lsu    (cand_lsu),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant_lsu   (grant_lsu)
  );

  always_comb begin
    sel_lsu  = owner_lsu;
    req_fire = 1'b0;
    resp_ifu = 1'b0;
    resp_lsu = 1'b0;
    unique case (state)
      ARB_IDLE: begin
        sel_lsu  = grant_lsu;
        req_fire = grant_valid;
        resp_lsu = grant_valid & grant_lsu & io_respValid;
        resp_ifu = grant_valid & ~grant_lsu & io_respValid;
      end
      ARB_BUSY: begin
        // Owner re-pulsing in its response cycle keeps the port.
        req_fire = io_respValid & own_req;
        resp_lsu = io_respValid & owner_lsu;
        resp_ifu = io_respValid & ~owner_lsu;
      end
      default: ;
    endcase
  end

  assign io_reqValid   = req_fire & ~reset;
  assign ifu_respValid = resp_ifu & ~reset;
  assign lsu_respValid = resp_lsu & ~reset;

  assign io_addr  = sel_lsu ? lsu_addr : ifu_addr;
  assign io_wdata = sel_lsu ? lsu_wdata : '0;
  assign io_size  = sel_lsu ? lsu_size : MEM_WORD;
  assign io_wen   = sel_lsu & lsu_wen;
  assign io_wmask = sel_lsu ? lsu_wmask : 4'b0000;

  assign ifu_rdata = io_rdata;
  assign lsu_rdata = io_rdata;

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ARB_IDLE;
      owner      <= OWN_IFU;
      pend_ifu   <= 1'b0;
      pend_lsu   <= 1'b0;
      last_grant <= 1'b0;
    end else begin
      unique case (state)
        ARB_IDLE: begin
          if (grant_valid) begin
            last_grant <= grant_lsu;
            owner      <= grant_lsu ? OWN_LSU : OWN_IFU;
            if (grant_lsu) begin
              pend_lsu <= 1'b0;
              if (ifu_reqValid) pend_ifu <= 1'b1;
            end else begin
              pend_ifu <= 1'b0;
              if (lsu_reqValid) pend_lsu <= 1'b1;
            end
            if (!io_respValid) state <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          if (owner_lsu) begin
            if (ifu_reqValid) pend_ifu <= 1'b1;
          end else begin
            if (lsu_reqValid) pend_lsu <= 1'b1;
          end
          if (io_respValid && !own_req) state <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a per-cycle reference model.
// Build option: MEM_ARB_LSU_PRIORITY_EN changes the expected tie winner.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ifu_reqValid = 1'b0;
  logic [31:0] ifu_addr = '0;
  logic        ifu_respValid;
  logic [31:0] ifu_rdata;
  logic        lsu_reqValid = 1'b0;
  logic [31:0] lsu_addr = '0;
  logic [31:0] lsu_wdata = '0;
  logic [1:0]  lsu_size = 2'b10;
  logic        lsu_wen = 1'b0;
  logic [3:0]  lsu_wmask = '0;
  logic        lsu_respValid;
  logic [31:0] lsu_rdata;
  logic        io_reqValid;
  logic        io_respValid = 1'b0;
  logic [31:0] io_addr;
  logic [31:0] io_wdata;
  logic [31:0] io_rdata = '0;
  logic [1:0]  io_size;
  logic        io_wen;
  logic [3:0]  io_wmask;

  int checks = 0;
  int passes = 0;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clock         (clock),
    .reset         (reset),
    .ifu_reqValid  (ifu_reqValid),
    .ifu_addr      (ifu_addr),
    .ifu_respValid (ifu_respValid),
    .ifu_rdata     (ifu_rdata),
    .lsu_reqValid  (lsu_reqValid),
    .lsu_addr      (lsu_addr),
    .lsu_wdata     (lsu_wdata),
    .lsu_size      (lsu_size),
    .lsu_wen       (lsu_wen),
    .lsu_wmask     (lsu_wmask),
    .lsu_respValid (lsu_respValid),
    .lsu_rdata     (lsu_rdata),
    .io_reqValid   (io_reqValid),
    .io_respValid  (io_respValid),
    .io_addr       (io_addr),
    .io_wdata      (io_wdata),
    .io_rdata      (io_rdata),
    .io_size       (io_size),
    .io_wen        (io_wen),
    .io_wmask      (io_wmask)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Reference model: who is on the bus (0 none, 1 IFU, 2 LSU),
  // who is waiting, and who won the last tie.
  int m_out  = 0;
  bit m_wi   = 0;
  bit m_wl   = 0;
  int m_last = 0;

  always begin : model
    int win;
    int sel;
    bit e_req, e_ri, e_rl, ci, cl, oreq;
    @(negedge clock);
    win = 0; sel = 0; e_req = 0; e_ri = 0; e_rl = 0;
    if (!reset) begin
      if (m_out == 0) begin
        ci = ifu_reqValid | m_wi;
        cl = lsu_reqValid | m_wl;
`ifdef MEM_ARB_LSU_PRIORITY_EN
        if (cl) win = 2; else if (ci) win = 1;
`else
        if (ci && cl) win = (m_last == 1) ? 1 : 2;
        else if (cl) win = 2;
        else if (ci) win = 1;
`endif
        sel   = win;
        e_req = (win != 0);
        e_ri  = (win == 1) && io_respValid;
        e_rl  = (win == 2) && io_respValid;
      end else begin
        sel   = m_out;
        oreq  = (m_out == 1) ? ifu_reqValid : lsu_reqValid;
        e_req = io_respValid && oreq;
        e_ri  = (m_out == 1) && io_respValid;
        e_rl  = (m_out == 2) && io_respValid;
      end
      if (ifu_reqValid)
        chk("proto_ifu", 32'(m_wi || (m_out == 1 && !io_respValid)), 0);
      if (lsu_reqValid)
        chk("proto_lsu", 32'(m_wl || (m_out == 2 && !io_respValid)), 0);
    end
    chk("io_reqValid", 32'(io_reqValid), 32'(e_req));
    chk("ifu_respValid", 32'(ifu_respValid), 32'(e_ri));
    chk("lsu_respValid", 32'(lsu_respValid), 32'(e_rl));
    chk("ifu_rdata", ifu_rdata, io_rdata);
    chk("lsu_rdata", lsu_rdata, io_rdata);
    if (e_req && sel == 1) begin
      chk("io_addr_ifu", io_addr, ifu_addr);
      chk("io_size_ifu", 32'(io_size), 32'(MEM_WORD));
      chk("io_wen_ifu", 32'(io_wen), 0);
      chk("io_wmask_ifu", 32'(io_wmask), 0);
      chk("io_wdata_ifu", io_wdata, 0);
    end
    if (e_req && sel == 2) begin
      chk("io_addr_lsu", io_addr, lsu_addr);
      chk("io_size_lsu", 32'(io_size), 32'(lsu_size));
      chk("io_wen_lsu", 32'(io_wen), 32'(lsu_wen));
      chk("io_wmask_lsu", 32'(io_wmask), 32'(lsu_wmask));
      chk("io_wdata_lsu", io_wdata, lsu_wdata);
    end
    @(posedge clock);
    if (reset) begin
      m_out = 0; m_wi = 0; m_wl = 0; m_last = 0;
    end else if (m_out == 0) begin
      if (win != 0) begin
        m_last = (win == 2) ? 1 : 0;
        if (win == 1) begin
          m_wi = 0;
          if (lsu_reqValid) m_wl = 1;
        end else begin
          m_wl = 0;
          if (ifu_reqValid) m_wi = 1;
        end
        m_out = io_respValid ? 0 : win;
      end
    end else begin
      if (m_out == 1 && lsu_reqValid) m_wl = 1;
      if (m_out == 2 && ifu_reqValid) m_wi = 1;
      oreq = (m_out == 1) ? ifu_reqValid : lsu_reqValid;
      if (io_respValid && !oreq) m_out = 0;
    end
  end

  logic [31:0] first_addr;
  logic [31:0] second_addr;

  initial begin
    // Reset, with a stray fetch pulse that must be swallowed.
    ifu_reqValid = 1'b1;
    step();
    chk("rst_io_req", 32'(io_reqValid), 0);
    step();
    reset = 1'b0;
    ifu_reqValid = 1'b0;
    #1;
    chk("post_rst_idle", 32'(io_reqValid), 0);

    // Lone IFU, zero-latency response.
    step();
    ifu_reqValid = 1'b1; ifu_addr = 32'h8000_0000;
    io_respValid = 1'b1; io_rdata = 32'h0000_0013;
    #1;
    chk("t1_req", 32'(io_reqValid), 1);
    chk("t1_size", 32'(io_size), 32'h2);
    chk("t1_resp", 32'(ifu_respValid), 1);
    chk("t1_rdata", ifu_rdata, 32'h13);
    step();
    ifu_reqValid = 1'b0; io_respValid = 1'b0;
    #1;
    chk("t1_idle", 32'(io_reqValid), 0);

    // Collision with last_grant=0: LSU first, IFU after a bubble.
    step();
    ifu_reqValid = 1'b1; ifu_addr = 32'h8000_0004;
    lsu_reqValid = 1'b1; lsu_addr = 32'h0000_1000;
    lsu_size = 2'b10; lsu_wen = 1'b0;
    #1;
    chk("t2_addr0", io_addr, 32'h1000);
    step();
    ifu_reqValid = 1'b0; lsu_reqValid = 1'b0;
    step();
    step();
    io_respValid = 1'b1; io_rdata = 32'hAAAA_5555;
    #1;
    chk("t2_lsu_resp", 32'(lsu_respValid), 1);
    chk("t2_no_cont", 32'(io_reqValid), 0);
    step();
    #1;
    chk("t2_ifu_req", 32'(io_reqValid), 1);
    chk("t2_ifu_addr", io_addr, 32'h8000_0004);
    chk("t2_ifu_resp", 32'(ifu_respValid), 1);
    step();
    io_respValid = 1'b0;

    // LSU store forwarded untouched.
    step();
    lsu_reqValid = 1'b1; lsu_addr = 32'h0000_2001;
    lsu_wen = 1'b1; lsu_wmask = 4'b0010;
    lsu_wdata = 32'h0000_AB00; lsu_size = 2'b00;
    #1;
    chk("st_wen", 32'(io_wen), 1);
    chk("st_wmask", 32'(io_wmask), 32'h2);
    chk("st_wdata", io_wdata, 32'h0000_AB00);
    step();
    lsu_reqValid = 1'b0; io_respValid = 1'b1;
    #1;
    chk("st_resp", 32'(lsu_respValid), 1);
    step();
    io_respValid = 1'b0; lsu_wen = 1'b0;
    lsu_wmask = 4'b0000; lsu_wdata = '0; lsu_size = 2'b10;

    // Collision with last_grant=1.
`ifdef MEM_ARB_LSU_PRIORITY_EN
    first_addr = 32'h0000_3000; second_addr = 32'h8000_0020;
`else
    first_addr = 32'h8000_0020; second_addr = 32'h0000_3000;
`endif
    step();
    ifu_reqValid = 1'b1; ifu_addr = 32'h8000_0020;
    lsu_reqValid = 1'b1; lsu_addr = 32'h0000_3000;
    io_respValid = 1'b1; io_rdata = 32'h1234_5678;
    #1;
    chk("t3_first", io_addr, first_addr);
    step();
    ifu_reqValid = 1'b0; lsu_reqValid = 1'b0;
    #1;
    chk("t3_second", io_addr, second_addr);
    chk("t3_second_req", 32'(io_reqValid), 1);
    step();
    io_respValid = 1'b0;

    // Misaligned two-beat LSU load stays atomic against a fetch.
    step();
    lsu_reqValid = 1'b1; lsu_addr = 32'h0000_1002;
    #1;
    chk("ma_beat0", io_addr, 32'h1002);
    step();
    lsu_reqValid = 1'b0;
    ifu_reqValid = 1'b1; ifu_addr = 32'h8000_0010;
    #1;
    chk("ma_busy", 32'(io_reqValid), 0);
    step();
    ifu_reqValid = 1'b0;
    io_respValid = 1'b1; io_rdata = 32'hDEAD_BEEF;
    lsu_reqValid = 1'b1; lsu_addr = 32'h0000_1004;
    #1;
    chk("ma_resp0", 32'(lsu_respValid), 1);
    chk("ma_beat1", io_addr, 32'h1004);
    chk("ma_beat1_req", 32'(io_reqValid), 1);
    step();
    lsu_reqValid = 1'b0; io_respValid = 1'b0;
    step();
    io_respValid = 1'b1;
    #1;
    chk("ma_resp1", 32'(lsu_respValid), 1);
    chk("ma_no_ifu", 32'(io_reqValid), 0);
    step();
    io_respValid = 1'b0;
    #1;
    chk("ma_ifu_addr", io_addr, 32'h8000_0010);
    chk("ma_ifu_req", 32'(io_reqValid), 1);
    step();
    io_respValid = 1'b1;
    #1;
    chk("ma_ifu_resp", 32'(ifu_respValid), 1);
    step();
    io_respValid = 1'b0;

    // Reset while busy with a fetch pending.
    step();
    lsu_reqValid = 1'b1; lsu_addr = 32'h0000_4000;
    step();
    lsu_reqValid = 1'b0;
    ifu_reqValid = 1'b1; ifu_addr = 32'h8000_0030;
    step();
    ifu_reqValid = 1'b0;
    reset = 1'b1; io_respValid = 1'b1;
    #1;
    chk("rb_lsu_resp", 32'(lsu_respValid), 0);
    chk("rb_io_req", 32'(io_reqValid), 0);
    step();
    reset = 1'b0; io_respValid = 1'b0;
    #1;
    chk("rb_no_pend", 32'(io_reqValid), 0);
    step();
    io_respValid = 1'b1;
    #1;
    chk("rb_no_lsu", 32'(lsu_respValid), 0);
    chk("rb_no_ifu", 32'(ifu_respValid), 0);
    step();
    io_respValid = 1'b0;
    step();
    step();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
